// File: rtl/bk_adder_pkg.sv
// Shared constants and helpers for the pipelined Brent-Kung adder/subtractor.
package bk_adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Fixed pipeline depth: operand decode, prefix network, output register.
    localparam int unsigned LATENCY = 3;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        while ((64'd1 << res) < 64'(value)) begin
            res++;
        end
        return res;
    endfunction

endpackage

// File: rtl/bk_prefix_tree.sv
// Combinational Brent-Kung carry network; carry-in is folded into bit 0 so every
// output carry is a plain group generate.
module bk_prefix_tree
    import bk_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] g,
    input  logic [WIDTH-1:0] p,
    input  logic             c0,
    output logic [WIDTH:1]   c
);

    localparam int unsigned LOG_W  = clog2(WIDTH);
    localparam int unsigned LEVELS = 2 * LOG_W - 1;

    // Level 0 holds bit (g,p); levels 1..LOG_W sweep up, the rest sweep down.
    for (genvar k = 0; k <= LEVELS; k++) begin : g_lvl
        logic [WIDTH-1:0] gg;
        logic [WIDTH-1:0] pp;

        if (k == 0) begin : g_init
            assign gg = {g[WIDTH-1:1], g[0] | (p[0] & c0)};
            assign pp = p;
        end else begin : g_comb
            localparam int unsigned STRIDE = (k <= LOG_W) ? (1 << k) : (1 << (2 * LOG_W - k));
            localparam int unsigned DIST   = STRIDE / 2;

            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                localparam bit HIT = (k <= LOG_W) ? (((i + 1) % STRIDE) == 0)
                                                  : ((((i + 1) % STRIDE) == DIST) && (i >= STRIDE));
                if (HIT) begin : g_op
                    assign gg[i] = g_lvl[k-1].gg[i] | (g_lvl[k-1].pp[i] & g_lvl[k-1].gg[i-DIST]);
                    assign pp[i] = g_lvl[k-1].pp[i] & g_lvl[k-1].pp[i-DIST];
                end else begin : g_pass
                    assign gg[i] = g_lvl[k-1].gg[i];
                    assign pp[i] = g_lvl[k-1].pp[i];
                end
            end
        end
    end

    assign c = g_lvl[LEVELS].gg;

    // Group propagates of the last level have no consumer.
    logic unused_pp;
    assign unused_pp = ^g_lvl[LEVELS].pp;

endmodule

// File: rtl/bk_adder_pipe.sv
// Three-stage Brent-Kung adder/subtractor with valid/ready flow control and
// carry/overflow/zero flags; the whole pipe advances or holds as one.
module bk_adder_pipe
    import bk_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    logic             en;
    logic [WIDTH-1:0] bop;
    logic             c0;
    logic             v1_q, v2_q, out_valid_q;
    logic [WIDTH-1:0] g1_q, p1_q, p2_q;
    logic             c0_1_q, c0_2_q;
    logic [WIDTH:1]   carry, c2_q;
    logic [WIDTH-1:0] sum_d, sum_q;
    logic             cout_q, ovf_q, zero_q;

    assign en       = ~out_valid_q | out_ready;
    assign in_ready = en;

    assign bop = (in_sub == OP_ADD) ? in_b : ~in_b;
    assign c0  = (in_sub == OP_SUB) ? 1'b1 : in_cin;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (en) begin
            v1_q        <= in_valid & in_ready;
            v2_q        <= v1_q;
            out_valid_q <= v2_q;
        end
    end

    // Datapath stages carry don't-care data alongside empty valid slots.
    always_ff @(posedge clk) begin
        if (en) begin
            g1_q   <= in_a & bop;
            p1_q   <= in_a ^ bop;
            c0_1_q <= c0;
            c2_q   <= carry;
            p2_q   <= p1_q;
            c0_2_q <= c0_1_q;
        end
    end

    bk_prefix_tree #(
        .WIDTH(WIDTH)
    ) u_tree (
        .g (g1_q),
        .p (p1_q),
        .c0(c0_1_q),
        .c (carry)
    );

    assign sum_d = p2_q ^ {c2_q[WIDTH-1:1], c0_2_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (en && v2_q) begin
            sum_q  <= sum_d;
            cout_q <= c2_q[WIDTH];
            ovf_q  <= c2_q[WIDTH] ^ c2_q[WIDTH-1];
            zero_q <= ~|sum_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;
    assign out_zero  = zero_q;

endmodule
